// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state type and target-sequence helper for the sequence game
package game_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } game_state_t;

    localparam int unsigned SEQ_MAX_W = 256;

    // Target sequences are zero-extended to SEQ_MAX_W bits so one helper serves every parameterisation.
    function automatic logic [31:0] seq_elem(input logic [SEQ_MAX_W-1:0] seq,
                                             input int unsigned k,
                                             input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return 32'(seq >> (k * idx_w)) & mask;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// rtl/onehot_decode.sv - classifies a move vector as none, one-hot (with index) or multi-hot
module onehot_decode #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid,
    output logic                 multi
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = ($clog2(N))'(i);
        end
        valid = ($countones(vec) == 1);
        multi = ($countones(vec) > 1);
    end

endmodule

// File: rtl/seq_game_fsm.sv
// rtl/seq_game_fsm.sv - player must reproduce a hidden move sequence within a try budget
module seq_game_fsm
    import game_pkg::*;
#(
    parameter int                     N_MOVES   = 4,
    parameter int                     SEQ_LEN   = 4,
    parameter int                     IDX_W     = $clog2(N_MOVES),
    parameter logic [SEQ_LEN*IDX_W-1:0] SEQ     = 8'hE4,
    parameter int                     MAX_TRIES = 9,
    parameter int                     CW        = $clog2(SEQ_LEN + 1),
    parameter int                     TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_MOVES-1:0] hMove,
    output logic [CW-1:0]      cMove,
    output logic [TW-1:0]      triesLeft,
    output logic               win,
    output logic               lose,
    output logic               illegal
);

    localparam logic [SEQ_MAX_W-1:0] SEQ_EXT = SEQ_MAX_W'(SEQ);

    game_state_t      state_q, state_d;
    logic [CW-1:0]    cmove_q, cmove_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             illegal_q, illegal_d;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             multi;

    onehot_decode #(.N(N_MOVES)) u_decode (
        .vec   (hMove),
        .idx   (idx),
        .valid (valid),
        .multi (multi)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PLAY;
            cmove_q   <= '0;
            tries_q   <= TW'(MAX_TRIES);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmove_q   <= cmove_d;
            tries_q   <= tries_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmove_d   = cmove_q;
        tries_d   = tries_q;
        illegal_d = 1'b0;
        if (state_q == PLAY) begin
            if (multi) begin
                illegal_d = 1'b1;
            end else if (valid) begin
                if (32'(idx) == seq_elem(SEQ_EXT, 32'(cmove_q), IDX_W)) begin
                    cmove_d = cmove_q + CW'(1);
                    if (cmove_q == CW'(SEQ_LEN - 1)) state_d = WIN;
                end else if (tries_q == TW'(1)) begin
                    // Last try spent: the restart-on-element-0 rule no longer applies.
                    state_d = LOSE;
                    tries_d = '0;
                    cmove_d = '0;
                end else begin
                    tries_d = tries_q - TW'(1);
                    cmove_d = (32'(idx) == seq_elem(SEQ_EXT, 0, IDX_W)) ? CW'(1) : '0;
                end
            end
        end
    end

    assign cMove     = cmove_q;
    assign triesLeft = tries_q;
    assign win       = (state_q == WIN);
    assign lose      = (state_q == LOSE);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_game_fsm.sv
// tb/tb_seq_game_fsm.sv - directed and randomized checks of seq_game_fsm against a move-level model
module tb_seq_game_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] hMove = '0;
    logic [2:0] cMove;
    logic [3:0] triesLeft;
    logic       win, lose, illegal;

    logic [7:0] hmove8 = '0;
    logic [1:0] cmove8;
    logic [3:0] tries8;
    logic       win8, lose8, illegal8;

    int checks = 0;
    int passed = 0;

    int tgt [4] = '{0, 1, 2, 3};
    int m_prog, m_tries, m_status, m_illegal;

    always #5 clock = ~clock;

    seq_game_fsm dut (
        .clock     (clock),
        .reset     (reset),
        .hMove     (hMove),
        .cMove     (cMove),
        .triesLeft (triesLeft),
        .win       (win),
        .lose      (lose),
        .illegal   (illegal)
    );

    seq_game_fsm #(.N_MOVES(8), .SEQ_LEN(2), .SEQ(6'b101_010), .MAX_TRIES(9)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .hMove     (hmove8),
        .cMove     (cmove8),
        .triesLeft (tries8),
        .win       (win8),
        .lose      (lose8),
        .illegal   (illegal8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cMove"},     32'(cMove),     32'(m_prog));
        check({tag, ".triesLeft"}, 32'(triesLeft), 32'(m_tries));
        check({tag, ".win"},       32'(win),       32'(m_status == 1));
        check({tag, ".lose"},      32'(lose),      32'(m_status == 2));
        check({tag, ".illegal"},   32'(illegal),   32'(m_illegal));
    endtask

    function automatic void model_reset();
        m_prog = 0; m_tries = 9; m_status = 0; m_illegal = 0;
    endfunction

    function automatic void model_step(input logic [3:0] h);
        int n, pos;
        m_illegal = 0;
        if (m_status != 0) return;
        n = $countones(h);
        if (n >= 2) begin
            m_illegal = 1;
        end else if (n == 1) begin
            pos = $clog2(h);
            if (pos == tgt[m_prog]) begin
                m_prog++;
                if (m_prog == 4) m_status = 1;
            end else begin
                m_tries--;
                if (m_tries == 0) begin
                    m_status = 2;
                    m_prog = 0;
                end else begin
                    m_prog = (pos == tgt[0]) ? 1 : 0;
                end
            end
        end
    endfunction

    task automatic apply(input logic [3:0] h, input string tag);
        @(negedge clock);
        hMove = h;
        @(posedge clock);
        #1;
        model_step(h);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        hMove = '0;
        hmove8 = '0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] h;
        int r;
        model_reset();

        do_reset("reset");

        apply(4'b0001, "win_seq1");
        apply(4'b0010, "win_seq2");
        apply(4'b0100, "win_seq3");
        apply(4'b1000, "win_seq4");
        check("win_const.cMove", 32'(cMove), 32'd4);
        check("win_const.win", 32'(win), 32'd1);

        do_reset("reset2");
        apply(4'b0001, "miss1");
        apply(4'b0010, "miss2");
        apply(4'b1000, "miss3");
        check("miss_const.tries", 32'(triesLeft), 32'd8);
        apply(4'b0001, "miss4");

        do_reset("reset3");
        apply(4'b0001, "rep1");
        apply(4'b0001, "rep2");
        check("rep_const.cMove", 32'(cMove), 32'd1);

        do_reset("reset4");
        for (int i = 0; i < 9; i++) apply(4'b0100, "lose_run");
        check("lose_const.lose", 32'(lose), 32'd1);
        apply(4'b0001, "lose_frozen1");
        apply(4'b0001, "lose_frozen2");

        do_reset("reset5");
        apply(4'b0001, "ill1");
        apply(4'b0010, "ill2");
        apply(4'b0011, "ill3");
        check("ill_const.illegal", 32'(illegal), 32'd1);
        apply(4'b0000, "ill4");

        do_reset("reset6");
        for (int i = 0; i < 8; i++) apply(4'b0100, "last_try_burn");
        apply(4'b0001, "last_try1");
        apply(4'b0010, "last_try2");
        apply(4'b0100, "last_try3");
        apply(4'b1000, "last_try_win");
        check("last_try_const.win", 32'(win), 32'd1);

        do_reset("reset7");
        apply(4'b0001, "mid1");
        apply(4'b0010, "mid2");
        do_reset("mid_reset");

        for (int g = 0; g < 400; g++) begin
            if ((m_status != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 40) == 0)
                do_reset("rnd_reset");
            r = $urandom_range(0, 9);
            if (r == 0)           h = 4'b0000;
            else if (r == 1)      h = 4'($urandom_range(0, 15));
            else if (r <= 5)      h = 4'b0001 << tgt[m_prog % 4];
            else                  h = 4'b0001 << $urandom_range(0, 3);
            apply(h, "rnd");
        end

        do_reset("reset8");
        @(negedge clock);
        hmove8 = 8'b0000_0100;
        @(negedge clock);
        hmove8 = 8'b0010_0000;
        @(negedge clock);
        hmove8 = 8'b0000_0000;
        check("p8.win", 32'(win8), 32'd1);
        check("p8.cMove", 32'(cmove8), 32'd2);
        check("p8.lose", 32'(lose8), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_game_fsm.md
Name: seq_game_fsm

Overview:
- Parametrised successor to the single-move game FSM: the player enters one-hot moves and must reproduce a hidden target sequence of SEQ_LEN moves.
- The machine reports progress (cMove), remaining tries, and win/lose status.
- It sits between the board switches/push-button clock and the seven-segment/LED drivers.
- Adds configurable move alphabet, sequence length, try budget, a lose condition and illegal-input detection.

Parameters:
- N_MOVES, 4, number of distinct moves; hMove width; must be >= 2.
- SEQ_LEN, 4, target sequence length; must be >= 1.
- IDX_W, $clog2(N_MOVES), width of one move index (derived).
- SEQ, 8'hE4, packed target sequence of SEQ_LEN*IDX_W bits; element k occupies bits [k*IDX_W +: IDX_W], element 0 at LSBs; default is 0,1,2,3.
- MAX_TRIES, 9, wrong moves allowed before losing; must be >= 1.
- CW, $clog2(SEQ_LEN+1), progress width (derived).
- TW, $clog2(MAX_TRIES+1), tries width (derived).

Ports:
- clock, input, 1, single clock; rising edge samples hMove.
- reset, input, 1, asynchronous, active-high.
- hMove, input, N_MOVES, one-hot player move; all-zero means no move.
- cMove, output, CW, progress: number of consecutive correct moves so far.
- triesLeft, output, TW, wrong moves still allowed.
- win, output, 1, high while in WIN.
- lose, output, 1, high while in LOSE.
- illegal, output, 1, one-cycle pulse after a multi-hot hMove is sampled.

Behaviour:
- All outputs are registered and change only on a clock edge or on reset.
- Reset (async, immediate): state=PLAY, cMove=0, triesLeft=MAX_TRIES, win=0, lose=0, illegal=0.
- States: PLAY, WIN, LOSE. WIN and LOSE are terminal until reset.
- Input decode each edge:
  - zero: no move;
  - exactly one bit set: valid move, index = bit position;
  - two or more bits set: illegal.
- PLAY, no move: hold all values; illegal=0.
- PLAY, illegal input: illegal=1 for that cycle; progress, tries and state unchanged.
- PLAY, valid move, index == SEQ[cMove]:
  - cMove <= cMove+1;
  - if cMove+1 == SEQ_LEN, go to WIN, win<=1, cMove holds SEQ_LEN.
- PLAY, valid move, index != SEQ[cMove]:
  - triesLeft <= triesLeft-1;
  - cMove <= 1 if index == SEQ[0], else 0 (restart, no overlap search beyond element 0);
  - if triesLeft == 1, go to LOSE, lose<=1, triesLeft=0, cMove<=0.
- Latency: result of the move sampled at edge n is visible after edge n (one clock).
- WIN/LOSE: all inputs ignored; outputs frozen; illegal forced 0.
- Simultaneous events: a correct final move always wins, even when triesLeft == 1. The tries counter never underflows and never exceeds MAX_TRIES.
- Reset asserted mid-game or mid-edge overrides everything. The first edge after deassertion is treated as normal PLAY input.
- win and lose are never high together.

Decomposition:
- Shared package game_pkg holds:
  - enum game_state_t {PLAY, WIN, LOSE};
  - a function returning the SEQ element for a given index.
- Sub-module onehot_decode (parameter N):
  - input vec[N-1:0];
  - outputs idx[$clog2(N)-1:0], valid (exactly one bit set), multi (two or more bits set);
  - purely combinational, instantiated once.

Test Plan:
- Reset then hMove 0001, 0010, 0100, 1000 on four edges -> cMove 1,2,3,4; win=1 after 4th edge; triesLeft=9; lose=0.
- After 0001,0010 apply 1000 -> cMove=0, triesLeft=8; then 0001 -> cMove=1, triesLeft still 8.
- At progress 1 apply 0001 (wrong, equals SEQ[0]) -> cMove=1, triesLeft=8.
- Nine wrong moves (0100 from reset) -> triesLeft 8..0, lose=1 after 9th; further 0001 edges leave cMove=0, lose=1.
- hMove 0011 at progress 2 -> illegal=1 for exactly one cycle, cMove=2, triesLeft unchanged; 0000 next edge -> illegal=0.
- Progress 3, triesLeft=1, then correct final move -> win=1, lose=0.
- Reset asserted between edges at progress 2 -> outputs return to reset values without a clock edge.
- Non-default check: N_MOVES=8, SEQ_LEN=2, SEQ=6'b101_010 -> moves 00000100 then 00100000 -> win=1.
